// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the JK flip-flop bank: operating modes, JK action
// encodings and the single-cell next-state rule.
package jk_ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    // {J,K} pair interpreted as an action on the cell
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_act_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        nq = q;
        case (jk_act_e'({j, k}))
            JK_HOLD:   nq = q;
            JK_RESET:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            JK_TOGGLE: nq = ~q;
            default:   nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One JK flip-flop cell with synchronous reset to a per-cell value,
// parallel load and clock enable (priority rst > ld > ce).
module jk_ff_cell
    import jk_ff_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ce,
    input  logic ld,
    input  logic ld_d,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= rst_val;
        else if (ld)
            q <= ld_d;
        else if (ce)
            q <= jk_next(q, j, k);
    end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK cells; the mode decoder turns JK, up/down count and serial
// shift into per-bit J/K vectors and drives a combinational terminal count.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc
);

    mode_e            mode_s;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] shin;
    logic             carry;
    logic             borrow;

    assign mode_s = mode_e'(mode);
    assign shin   = {q[WIDTH-2:0], ser_in};

    // Carry/borrow ripple: bit i toggles when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        up_t   = '0;
        dn_t   = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            up_t[i] = carry;
            dn_t[i] = borrow;
            carry   = carry & q[i];
            borrow  = borrow & ~q[i];
        end
    end

    always_comb begin
        jv = '0;
        kv = '0;
        case (mode_s)
            MODE_JK:    begin jv = j;     kv = k;     end
            MODE_UP:    begin jv = up_t;  kv = up_t;  end
            MODE_DOWN:  begin jv = dn_t;  kv = dn_t;  end
            MODE_SHIFT: begin jv = shin;  kv = ~shin; end
            default:    begin jv = '0;    kv = '0;    end
        endcase
    end

    always_comb begin
        tc = 1'b0;
        if (!rst && en && !load) begin
            if (mode_s == MODE_UP && (&q))
                tc = 1'b1;
            else if (mode_s == MODE_DOWN && !(|q))
                tc = 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[g]),
            .ce      (en),
            .ld      (load),
            .ld_d    (d[g]),
            .j       (jv[g]),
            .k       (kv[g]),
            .q       (q[g])
        );
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Self-checking bench for jk_ff_bank (WIDTH=4): table of directed vectors
// plus modelled count/shift sequences, expectations queued per driven edge.
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    logic       ser_in = 1'b0;
    logic [3:0] q;
    logic [3:0] q_n;
    logic       tc;

    int unsigned checks = 0;
    int unsigned passes = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [1:0] mode;
        logic [3:0] d;
        logic [3:0] j;
        logic [3:0] k;
        logic       ser;
        logic [3:0] eq;
        logic       etc;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       tc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    jk_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .load   (load),
        .d      (d),
        .j      (j),
        .k      (k),
        .ser_in (ser_in),
        .q      (q),
        .q_n    (q_n),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic l,
                                input logic [1:0] m, input logic [3:0] dd,
                                input logic [3:0] jj, input logic [3:0] kk,
                                input logic s, input logic [3:0] eq, input logic et);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.mode = m; v.d = dd;
        v.j = jj; v.k = kk; v.ser = s; v.eq = eq; v.etc = et;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        rst = v.rst; en = v.en; load = v.load; mode = v.mode;
        d = v.d; j = v.j; k = v.k; ser_in = v.ser;
        sb.push_back('{q: v.eq, tc: v.etc});
        #1;
        checks++;
        if (tc === sb[0].tc) passes++;
        else $display("FAIL %s tc: got %b expected %b", name, tc, sb[0].tc);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (q === e.q) passes++;
        else $display("FAIL %s q: got %h expected %h", name, q, e.q);
        checks++;
        if (q_n === ~e.q) passes++;
        else $display("FAIL %s q_n: got %h expected %h", name, q_n, ~e.q);
    endtask

    initial begin
        logic [3:0] m;
        logic       b;
        vec_t       v;

        // reset, then count up to 5 and reset mid-count
        tbl.push_back(mk(1, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0, 1, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'(i), 0));
        tbl.push_back(mk(1, 1, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0));
        // per-bit JK
        tbl.push_back(mk(1, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 0, 2'b00, 4'h0, 4'b0011, 4'b0000, 0, 4'b0011, 0));
        tbl.push_back(mk(0, 1, 0, 2'b00, 4'h0, 4'b1111, 4'b1111, 0, 4'b1100, 0));
        tbl.push_back(mk(0, 1, 0, 2'b00, 4'h0, 4'b0000, 4'b0100, 0, 4'b1000, 0));
        // up wrap, enable gating of tc
        tbl.push_back(mk(0, 1, 1, 2'b01, 4'hE, 4'h0, 4'h0, 0, 4'hE, 0));
        tbl.push_back(mk(0, 1, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 1, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'h0, 1));
        tbl.push_back(mk(0, 1, 1, 2'b01, 4'hF, 4'h0, 4'h0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 4'h3, 4'h0, 4'h0, 0, 4'h3, 0));
        // down wrap
        tbl.push_back(mk(0, 1, 1, 2'b10, 4'h1, 4'h0, 4'h0, 0, 4'h1, 0));
        tbl.push_back(mk(0, 1, 0, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 0, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'hF, 1));
        // serial shift
        tbl.push_back(mk(1, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0001, 0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 0, 4'b0010, 0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0101, 0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b1011, 0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, 0, 4'b0110, 0));
        // priority: load beats en=0, rst beats load
        tbl.push_back(mk(0, 0, 1, 2'b00, 4'hA, 4'hF, 4'hF, 0, 4'hA, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'h0, 4'hF, 4'hF, 0, 4'hA, 0));
        tbl.push_back(mk(1, 1, 1, 2'b01, 4'h5, 4'h0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // modelled up count across the wrap
        m = 4'(11);
        apply(mk(0, 1, 1, 2'b01, m, 4'h0, 4'h0, 0, m, 0), "seq_up_load");
        for (int i = 0; i < 20; i++) begin
            v = mk(0, 1, 0, 2'b01, 4'h0, 4'($urandom), 4'($urandom), 1'($urandom),
                   m + 4'd1, (m == 4'hF));
            m = m + 4'd1;
            apply(v, $sformatf("seq_up%0d", i));
        end

        // modelled down count across the wrap
        for (int i = 0; i < 20; i++) begin
            v = mk(0, 1, 0, 2'b10, 4'h0, 4'($urandom), 4'($urandom), 1'($urandom),
                   m - 4'd1, (m == 4'h0));
            m = m - 4'd1;
            apply(v, $sformatf("seq_dn%0d", i));
        end

        // modelled serial shift with random data
        for (int i = 0; i < 12; i++) begin
            b = 1'($urandom);
            v = mk(0, 1, 0, 2'b11, 4'h0, 4'h0, 4'h0, b, {m[2:0], b}, 0);
            m = {m[2:0], b};
            apply(v, $sformatf("seq_sh%0d", i));
        end

        @(negedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
